next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Parametrised successor to the IF-stage next-PC selector.
- Owns the fetch PC register and arbitrates NUM_SRC prioritised redirect channels (exception, eret, refetch, branch/jump, …) against sequential advance by a configurable fetch width.
- Presents the PC to the fetch stage over a valid/ready handshake.
- Buffers a redirect that arrives while fetch is back-pressured, so no redirect is lost.

Parameters:
PC_WIDTH, 32, width of PC and redirect targets
NUM_SRC, 4, number of redirect channels; index 0 = highest priority
FETCH_BYTES, 8, bytes fetched per accepted request; power of two, >= 4
RESET_VECTOR, 32'hBFC0_0000, first PC after reset
SEL_W, $clog2(NUM_SRC+1), width of pc_sel (localparam)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
redirect_valid  input  NUM_SRC  per-channel redirect request, single-cycle pulse
redirect_target  input  NUM_SRC*PC_WIDTH  channel i target in bits [i*PC_WIDTH +: PC_WIDTH]
fetch_ready  input  1  fetch stage accepts fetch_pc this cycle
fetch_valid  output  1  fetch_pc is valid
fetch_pc  output  PC_WIDTH  current fetch address
pc_sel  output  SEL_W  source of next PC this cycle: channel index, or NUM_SRC = sequential
redirect_pending  output  1  buffered redirect awaiting handshake
fetch_pc_misalign  output  1  fetch_pc[1:0] != 0 (combinational)

Behaviour:
- Reset (async assert, sync release): pc=RESET_VECTOR, fetch_valid=0, pending=0, pending_idx=0, pending_target=0.
- fetch_valid rises on the first clock edge after reset release, then stays 1 forever.
- Handshake hs = fetch_valid & fetch_ready. fetch_pc is held stable while fetch_valid & !fetch_ready. It changes only on hs, with one exception: before the first valid cycle, a redirect may replace the reset vector.
- Winner: lowest index i with redirect_valid[i]=1 (fixed priority). any_redir = |redirect_valid.
- Next-PC priority at hs:
  1. any_redir → target[winner]
  2. else pending → pending_target
  3. else sequential: (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^PC_WIDTH (0xFFFF_FFF8 → 0x0 wraps silently).
- Redirect targets are loaded unaligned. Sequential advance realigns to the FETCH_BYTES boundary.
- pc_sel (combinational) matches the rule applied: winner, pending_idx, or NUM_SRC. It is driven every cycle even without hs.
- Pending buffer:
  - On hs: pending cleared.
  - Not hs and any_redir: capture (winner, target) if !pending, or if winner <= pending_idx. Equal priority means the newer redirect wins; a lower-priority arrival is dropped.
  - A same-cycle redirect always beats pending.
- Before first valid (fetch_valid=0) with any_redir: pc <= target[winner] directly; pending is not set.
- redirect_pending = pending register.
- All state updates on posedge clk; no combinational path from fetch_ready to fetch_pc.

Decomposition:
- Package pc_sel_pkg holds:
  - channel index localparams SRC_EXCEPT=0, SRC_ERET=1, SRC_REFETCH=2, SRC_BRANCH=3
  - default RESET_VECTOR
  - the SEL_W function.
- One sub-module fixed_prio_arb: parameter N; input req[N]; outputs grant index, any. Pure combinational find-first-one.

Test Plan:
- Reset then fetch_ready=1 constantly, FETCH_BYTES=8 → fetch_pc 0xBFC00000, 0xBFC00008, 0xBFC00010; pc_sel=4; fetch_valid 0 for 1 cycle after resetn rises.
- At pc 0xBFC00008, hold fetch_ready=0 and pulse redirect_valid[3] (target 0x80001234) → fetch_pc stays 0xBFC00008, redirect_pending=1. Raise fetch_ready → next fetch_pc 0x80001234, pending clears. The following fetch_pc is 0x80001238 (aligned advance).
- fetch_ready=0:
  - pulse ch3 (0x1000), then ch0 (0xBFC00380) → pending_idx=0.
  - then pulse ch2 (0x2000) → ignored.
  - On hs → 0xBFC00380.
- Pending ch3=0x1000 while ch1 pulses (0x3000) in the same cycle as hs → fetch_pc 0x3000, pc_sel=1, pending cleared.
- pc=0xFFFFFFF8 sequential with hs → 0x00000000. Redirect to 0x00000402 → fetch_pc_misalign=1, next sequential 0x00000408.
- Assert resetn=0 mid-stream with pending=1 → outputs reset immediately (async). After release, fetch_pc=0xBFC00000 and redirect_pending=0.

Source files
------------

// File: rtl/pc_sel_pkg.sv
// Shared constants for the IF-stage next-PC selector.
// Channel indices double as redirect priorities (0 = highest).
package pc_sel_pkg;

    localparam int SRC_EXCEPT  = 0;
    localparam int SRC_ERET    = 1;
    localparam int SRC_REFETCH = 2;
    localparam int SRC_BRANCH  = 3;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    // One extra code point encodes "sequential advance".
    function automatic int selWidth(input int numSrc);
        return $clog2(numSrc + 1);
    endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// Find-first-one arbiter: lowest requesting index wins.
// Pure combinational; grant is zero when nothing requests.
module fixed_prio_arb
    import pc_sel_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = selWidth(N)
) (
    input  logic [N-1:0]  req,
    output logic [GW-1:0] grant,
    output logic          any
);

    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant = GW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with prioritised redirects, sequential
// advance and a one-entry buffer for back-pressured redirects.
module next_pc_unit
    import pc_sel_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int NUM_SRC     = 4,
    parameter int FETCH_BYTES = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR =
        PC_WIDTH'(DEFAULT_RESET_VECTOR),
    localparam int SEL_W = selWidth(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_SRC-1:0]          redirect_valid,
    input  logic [NUM_SRC*PC_WIDTH-1:0] redirect_target,
    input  logic                        fetch_ready,
    output logic                        fetch_valid,
    output logic [PC_WIDTH-1:0]         fetch_pc,
    output logic [SEL_W-1:0]            pc_sel,
    output logic                        redirect_pending,
    output logic                        fetch_pc_misalign
);

    localparam logic [PC_WIDTH-1:0] STEP =
        PC_WIDTH'(FETCH_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
        ~(PC_WIDTH'(FETCH_BYTES - 1));
    localparam logic [SEL_W-1:0] SEL_SEQ =
        SEL_W'(NUM_SRC);

    logic [PC_WIDTH-1:0] pc;
    logic                validQ;
    logic                pending;
    logic [SEL_W-1:0]    pendingIdx;
    logic [PC_WIDTH-1:0] pendingTarget;

    logic [SEL_W-1:0]    winIdx;
    logic                anyRedir;
    logic [PC_WIDTH-1:0] winTarget;
    logic [PC_WIDTH-1:0] seqPc;
    logic [PC_WIDTH-1:0] nextPc;
    logic                hs;
    logic                capture;

    fixed_prio_arb #(
        .N  (NUM_SRC),
        .GW (SEL_W)
    ) uArb (
        .req   (redirect_valid),
        .grant (winIdx),
        .any   (anyRedir)
    );

    always_comb begin
        winTarget = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winIdx == SEL_W'(i)) begin
                winTarget =
                    redirect_target[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    assign hs    = validQ & fetch_ready;
    assign seqPc = (pc & ALIGN_MASK) + STEP;

    // A same-cycle redirect always beats the buffered one.
    always_comb begin
        nextPc = seqPc;
        pc_sel = SEL_SEQ;
        if (anyRedir) begin
            nextPc = winTarget;
            pc_sel = winIdx;
        end else if (pending) begin
            nextPc = pendingTarget;
            pc_sel = pendingIdx;
        end
    end

    // Equal priority replaces (newer wins); lower is dropped.
    assign capture = validQ & !hs & anyRedir &
                     (!pending | (winIdx <= pendingIdx));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc     <= RESET_VECTOR;
            validQ <= 1'b0;
        end else begin
            validQ <= 1'b1;
            if (hs) begin
                pc <= nextPc;
            end else if (!validQ && anyRedir) begin
                pc <= winTarget;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending       <= 1'b0;
            pendingIdx    <= '0;
            pendingTarget <= '0;
        end else if (hs) begin
            pending <= 1'b0;
        end else if (capture) begin
            pending       <= 1'b1;
            pendingIdx    <= winIdx;
            pendingTarget <= winTarget;
        end
    end

    assign fetch_valid       = validQ;
    assign fetch_pc          = pc;
    assign redirect_pending  = pending;
    assign fetch_pc_misalign = |pc[1:0];

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed vector table, reset
// sequences, then random traffic against a queue-based model.
module tb_next_pc_unit;
    import pc_sel_pkg::*;

    localparam int PW = 32;
    localparam int NS = 4;
    localparam int FB = 8;
    localparam int SW = selWidth(NS);
    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NS-1:0]     rv;
    logic [NS*PW-1:0]  rt;
    logic              ready;
    logic              fValid;
    logic [PW-1:0]     fPc;
    logic [SW-1:0]     sel;
    logic              pend;
    logic              mis;

    int passCnt  = 0;
    int totalCnt = 0;

    next_pc_unit #(
        .PC_WIDTH     (PW),
        .NUM_SRC      (NS),
        .FETCH_BYTES  (FB),
        .RESET_VECTOR (RV)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .redirect_valid    (rv),
        .redirect_target   (rt),
        .fetch_ready       (ready),
        .fetch_valid       (fValid),
        .fetch_pc          (fPc),
        .pc_sel            (sel),
        .redirect_pending  (pend),
        .fetch_pc_misalign (mis)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h",
                      name, act, exp);
    endtask

    // Non-pulsing channels carry random decoy targets.
    task automatic drive(input logic r,
                         input logic [NS-1:0] v,
                         input logic [PW-1:0] t);
        ready = r;
        rv    = v;
        for (int i = 0; i < NS; i++)
            rt[i*PW +: PW] = v[i] ? t : PW'($urandom());
    endtask

    task automatic checkAll(input string tag,
                            input logic eV,
                            input logic [PW-1:0] ePc,
                            input logic [SW-1:0] eSel,
                            input logic ePend);
        check({tag, " valid"}, 64'(fValid), 64'(eV));
        check({tag, " pc"}, 64'(fPc), 64'(ePc));
        check({tag, " sel"}, 64'(sel), 64'(eSel));
        check({tag, " pend"}, 64'(pend), 64'(ePend));
        check({tag, " mis"}, 64'(mis), 64'(ePc[1:0] != 2'b00));
    endtask

    typedef struct {
        logic          rdy;
        logic [NS-1:0] v;
        logic [PW-1:0] t;
        logic          eV;
        logic [PW-1:0] ePc;
        logic [SW-1:0] eSel;
        logic          ePend;
    } vec_t;

    vec_t vecs[18];

    typedef struct {
        int            idx;
        logic [PW-1:0] tgt;
    } redir_t;

    logic [PW-1:0] mPc;
    logic          mValid;
    redir_t        mQ[$];

    function automatic int winnerOf(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic modelStep();
        int w;
        logic [PW-1:0] t;
        w = winnerOf(rv);
        t = (w >= 0) ? rt[w*PW +: PW] : '0;
        if (mValid && ready) begin
            if (w >= 0) mPc = t;
            else if (mQ.size() > 0) mPc = mQ[0].tgt;
            else mPc = mPc - (mPc % FB) + PW'(FB);
            mQ.delete();
        end else if (!mValid) begin
            if (w >= 0) mPc = t;
        end else if (w >= 0) begin
            if (mQ.size() == 0 || w <= mQ[0].idx) begin
                mQ.delete();
                mQ.push_back('{w, t});
            end
        end
        mValid = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1, 4'h0, 0, 0, RV, 3'd4, 0};
        vecs[1]  = '{1, 4'h0, 0, 1, RV, 3'd4, 0};
        vecs[2]  = '{0, 4'h8, 32'h80001234, 1, 32'hBFC00008, 3'd3, 0};
        vecs[3]  = '{0, 4'h0, 0, 1, 32'hBFC00008, 3'd3, 1};
        vecs[4]  = '{1, 4'h0, 0, 1, 32'hBFC00008, 3'd3, 1};
        vecs[5]  = '{1, 4'h0, 0, 1, 32'h80001234, 3'd4, 0};
        vecs[6]  = '{0, 4'h8, 32'h1000, 1, 32'h80001238, 3'd3, 0};
        vecs[7]  = '{0, 4'h1, 32'hBFC00380, 1, 32'h80001238, 3'd0, 1};
        vecs[8]  = '{0, 4'h4, 32'h2000, 1, 32'h80001238, 3'd2, 1};
        vecs[9]  = '{1, 4'h0, 0, 1, 32'h80001238, 3'd0, 1};
        vecs[10] = '{0, 4'h8, 32'h1000, 1, 32'hBFC00380, 3'd3, 0};
        vecs[11] = '{1, 4'h2, 32'h3000, 1, 32'hBFC00380, 3'd1, 1};
        vecs[12] = '{1, 4'h0, 0, 1, 32'h3000, 3'd4, 0};
        vecs[13] = '{1, 4'h8, 32'hFFFFFFF8, 1, 32'h3008, 3'd3, 0};
        vecs[14] = '{1, 4'h0, 0, 1, 32'hFFFFFFF8, 3'd4, 0};
        vecs[15] = '{1, 4'h4, 32'h402, 1, 32'h0, 3'd2, 0};
        vecs[16] = '{1, 4'h0, 0, 1, 32'h402, 3'd4, 0};
        vecs[17] = '{0, 4'h2, 32'h5000, 1, 32'h408, 3'd1, 0};

        resetn = 1'b0;
        drive(0, '0, '0);
        repeat (2) @(negedge clk);
        #1 checkAll("reset", 0, RV, 3'd4, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(vecs[k].rdy, vecs[k].v, vecs[k].t);
            #1 checkAll($sformatf("vec%0d", k), vecs[k].eV,
                        vecs[k].ePc, vecs[k].eSel,
                        vecs[k].ePend);
        end

        // Async reset with a buffered redirect outstanding.
        @(negedge clk);
        drive(0, '0, '0);
        #1 checkAll("prerst", 1, 32'h408, 3'd1, 1);
        #2 resetn = 1'b0;
        #1 checkAll("asyncrst", 0, RV, 3'd4, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Redirect before the first valid cycle replaces RV.
        @(negedge clk);
        drive(1, 4'h1, 32'h0000ABC0);
        #1 checkAll("prevalid", 0, RV, 3'd0, 0);
        @(negedge clk);
        drive(1, '0, '0);
        #1 checkAll("firstvalid", 1, 32'hABC0, 3'd4, 0);
        @(negedge clk);
        #1 checkAll("afterpre", 1, 32'hABC8, 3'd4, 0);

        @(negedge clk);
        resetn = 1'b0;
        drive(0, '0, '0);
        mPc    = RV;
        mValid = 1'b0;
        mQ.delete();
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int c = 0; c < 600; c++) begin
            logic [NS-1:0] v;
            @(negedge clk);
            for (int i = 0; i < NS; i++)
                v[i] = ($urandom_range(0, 5) == 0);
            ready = ($urandom_range(0, 9) < 6);
            rv    = v;
            for (int i = 0; i < NS; i++) begin
                rt[i*PW +: PW] = PW'($urandom());
                if ($urandom_range(0, 7) == 0)
                    rt[i*PW +: PW] = 32'hFFFFFFE0
                        | PW'($urandom_range(0, 31));
            end
            #1;
            begin
                int w;
                logic [SW-1:0] eSel;
                w = winnerOf(rv);
                if (w >= 0) eSel = SW'(w);
                else if (mQ.size() > 0) eSel = SW'(mQ[0].idx);
                else eSel = SW'(NS);
                checkAll($sformatf("rnd%0d", c), mValid, mPc,
                         eSel, mQ.size() > 0);
            end
            modelStep();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
